// File: rtl/counter_ctrl_in_pkg.sv
// Shared definitions for the counter_ctrl_in button conditioner: FSM encoding,
// button indices and default timing parameters.
package counter_ctrl_in_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    localparam int NUM_BTN   = 4;
    localparam int BTN_START = 0;
    localparam int BTN_STOP  = 1;
    localparam int BTN_RST   = 2;
    localparam int BTN_TGL   = 3;

    localparam int DB_CYCLES_DEF  = 16;
    localparam int CLR_CYCLES_DEF = 2;

endpackage

// File: rtl/counter_ctrl_in_if.sv
// Button inputs and level controls between the push-button panel and counter_top.
interface counter_ctrl_in_if;
    logic btn_start;
    logic btn_stop;
    logic btn_rst;
    logic btn_tgl;
    logic cnt_start;
    logic cnt_stop;
    logic cnt_rst;
    logic disp_tgl;

    modport master (
        output btn_start, btn_stop, btn_rst, btn_tgl,
        input  cnt_start, cnt_stop, cnt_rst, disp_tgl
    );

    modport slave (
        input  btn_start, btn_stop, btn_rst, btn_tgl,
        output cnt_start, cnt_stop, cnt_rst, disp_tgl
    );
endinterface

// File: rtl/counter_ctrl_in_btn_debounce.sv
// One button path: 2-FF synchronizer, stability counter and a registered
// one-cycle press pulse on each accepted 0->1 transition.
module btn_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          db_reg;
    logic          db_d_reg;
    logic          press_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            db_reg    <= 1'b0;
            db_d_reg  <= 1'b0;
            press_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= btn_raw;
            sync2_reg <= sync1_reg;
            db_d_reg  <= db_reg;
            press_reg <= db_reg & ~db_d_reg;
            // The flip happens on the sample that would bring the count to DB_CYCLES.
            if (sync2_reg == db_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CW'(DB_CYCLES - 1)) begin
                db_reg  <= sync2_reg;
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/counter_ctrl_in.sv
// Debounces four push-buttons and drives legal run/hold/clear/display levels to
// counter_top. Optional ctrl_err output is enabled by defining CTRL_ERR_FLAG_EN.
module counter_ctrl_in
    import counter_ctrl_in_pkg::*;
#(
    parameter int DB_CYCLES  = DB_CYCLES_DEF,
    parameter int CLR_CYCLES = CLR_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
`ifdef CTRL_ERR_FLAG_EN
    output logic ctrl_err,
`endif
    counter_ctrl_in_if.slave bus
);
    localparam int                CLR_W    = $clog2(CLR_CYCLES + 1);
    localparam logic [CLR_W-1:0]  CLR_INIT = CLR_W'(CLR_CYCLES - 1);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] press;

    assign raw[BTN_START] = bus.btn_start;
    assign raw[BTN_STOP]  = bus.btn_stop;
    assign raw[BTN_RST]   = bus.btn_rst;
    assign raw[BTN_TGL]   = bus.btn_tgl;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
                .clk     (clk),
                .rst     (rst),
                .btn_raw (raw[gi]),
                .press   (press[gi])
            );
        end
    endgenerate

    state_t           state_reg, state_next;
    logic [CLR_W-1:0] clr_reg, clr_next;
    logic             cnt_start_reg, cnt_stop_reg, cnt_rst_reg, disp_reg;

    // Highest-priority event wins; anything that arrives during CLEAR is dropped.
    always_comb begin
        state_next = state_reg;
        clr_next   = clr_reg;
        if (state_reg == ST_CLEAR) begin
            if (clr_reg == '0) state_next = ST_IDLE;
            else               clr_next   = clr_reg - CLR_W'(1);
        end else if (press[BTN_RST]) begin
            state_next = ST_CLEAR;
            clr_next   = CLR_INIT;
        end else if (press[BTN_STOP]) begin
            if (state_reg == ST_RUN) state_next = ST_HOLD;
        end else if (press[BTN_START]) begin
            state_next = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            clr_reg       <= '0;
            cnt_start_reg <= 1'b0;
            cnt_stop_reg  <= 1'b0;
            cnt_rst_reg   <= 1'b0;
            disp_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            clr_reg       <= clr_next;
            cnt_start_reg <= (state_next == ST_RUN);
            cnt_stop_reg  <= (state_next == ST_HOLD);
            cnt_rst_reg   <= (state_next == ST_CLEAR);
            if (press[BTN_TGL]) disp_reg <= ~disp_reg;
        end
    end

    assign bus.cnt_start = cnt_start_reg;
    assign bus.cnt_stop  = cnt_stop_reg;
    assign bus.cnt_rst   = cnt_rst_reg;
    assign bus.disp_tgl  = disp_reg;

`ifdef CTRL_ERR_FLAG_EN
    logic err_next, err_reg;

    always_comb begin
        err_next = 1'b0;
        if (state_reg == ST_CLEAR)
            err_next = press[BTN_START] | press[BTN_STOP] | press[BTN_RST];
        else
            err_next = (press[BTN_START] & press[BTN_STOP]) |
                       (press[BTN_START] & press[BTN_RST])  |
                       (press[BTN_STOP]  & press[BTN_RST]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_reg <= 1'b0;
        else      err_reg <= err_next;
    end

    assign ctrl_err = err_reg;
`endif

endmodule

// File: tb/tb_counter_ctrl_in.sv
// Directed bench for counter_ctrl_in with DB_CYCLES=4, CLR_CYCLES=2: vector table
// plus hand sequences for exact-edge latency, CLEAR and reset corner cases.
`timescale 1ns/1ps
module tb_counter_ctrl_in;
    localparam int DB  = 4;
    localparam int CLR = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    counter_ctrl_in_if bus ();
`ifdef CTRL_ERR_FLAG_EN
    logic ctrl_err;
`endif

    counter_ctrl_in #(.DB_CYCLES(DB), .CLR_CYCLES(CLR)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef CTRL_ERR_FLAG_EN
        .ctrl_err (ctrl_err),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int failed   = 0;

    typedef struct {
        logic [3:0] btn;   // {start, stop, rst, tgl}
        int         cyc;
        logic [3:0] exp;   // {cnt_start, cnt_stop, cnt_rst, disp_tgl}
    } vec_t;

    vec_t tbl[16];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic [3:0] b);
        {bus.btn_start, bus.btn_stop, bus.btn_rst, bus.btn_tgl} = b;
    endtask

    task automatic check(input string name, input logic [3:0] exp);
        logic [3:0] act;
        act = {bus.cnt_start, bus.cnt_stop, bus.cnt_rst, bus.disp_tgl};
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: outputs %b, expected %b", name, act, exp);
        end else begin
            $display("check %s: outputs %b ok", name, act);
        end
    endtask

`ifdef CTRL_ERR_FLAG_EN
    task automatic check_err(input string name, input logic exp);
        compared++;
        if (ctrl_err !== exp) begin
            failed++;
            $display("FAIL %s: ctrl_err %b, expected %b", name, ctrl_err, exp);
        end else begin
            $display("check %s: ctrl_err %b ok", name, ctrl_err);
        end
    endtask
`endif

    // At most one count control may be high in any cycle.
    always @(negedge clk) begin
        if (rst) begin
            compared++;
            if ((32'(bus.cnt_start) + 32'(bus.cnt_stop) + 32'(bus.cnt_rst)) > 1) begin
                failed++;
                $display("FAIL onehot: start=%b stop=%b rst=%b, expected at most one high",
                         bus.cnt_start, bus.cnt_stop, bus.cnt_rst);
            end
        end
    end

    initial begin
        tbl[0]  = '{4'b0001, 10, 4'b0001};
        tbl[1]  = '{4'b0000, 10, 4'b0001};
        tbl[2]  = '{4'b0001, 10, 4'b0000};
        tbl[3]  = '{4'b0000, 10, 4'b0000};
        tbl[4]  = '{4'b0001, 10, 4'b0001};
        tbl[5]  = '{4'b0000, 10, 4'b0001};
        tbl[6]  = '{4'b1000, 10, 4'b1001};
        tbl[7]  = '{4'b0000, 10, 4'b1001};
        tbl[8]  = '{4'b0100, 10, 4'b0101};
        tbl[9]  = '{4'b0000, 10, 4'b0101};
        tbl[10] = '{4'b1000, 10, 4'b1001};
        tbl[11] = '{4'b0000, 10, 4'b1001};
        tbl[12] = '{4'b0101, 10, 4'b0100};
        tbl[13] = '{4'b0000, 10, 4'b0100};
        tbl[14] = '{4'b0010, 10, 4'b0000};
        tbl[15] = '{4'b0000, 10, 4'b0000};

        set_btn(4'b0000);
        step(3);
        check("reset_state", 4'b0000);
        rst = 1'b1;

        // 1: idle quiet period, then exact start latency
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("t1_idle", 4'b0000);
        end
        set_btn(4'b1000);
        step(7);
        check("t1_start_edge6", 4'b0000);
        step(1);
        check("t1_start_edge7", 4'b1000);
        step(2);
        set_btn(4'b0000);
        step(10);
        check("t1_release", 4'b1000);

        // 2: bouncing stop must not leak through
        for (int s = 0; s < 6; s++) begin
            set_btn((s % 2 == 0) ? 4'b0100 : 4'b0000);
            for (int c = 0; c < 2; c++) begin
                step(1);
                check("t2_bounce", 4'b1000);
            end
        end
        set_btn(4'b0100);
        step(7);
        check("t2_stop_edge6", 4'b1000);
        step(1);
        check("t2_stop_edge7", 4'b0100);
        set_btn(4'b0000);
        step(10);
        set_btn(4'b1000);
        step(7);
        check("t2_restart_edge6", 4'b0100);
        step(1);
        check("t2_restart_edge7", 4'b1000);
        set_btn(4'b0000);
        step(10);

        // 3: HOLD -> CLEAR, start debounced inside CLEAR is dropped
        set_btn(4'b0100);
        step(10);
        check("t3_hold", 4'b0100);
        set_btn(4'b0000);
        step(10);
        set_btn(4'b0010);
        step(1);
        set_btn(4'b1010);
        step(6);
        check("t3_pre_clear", 4'b0100);
        step(1);
        check("t3_clear1", 4'b0010);
`ifdef CTRL_ERR_FLAG_EN
        check_err("t3_err_rst_only", 1'b0);
`endif
        step(1);
        check("t3_clear2", 4'b0010);
`ifdef CTRL_ERR_FLAG_EN
        check_err("t3_err_discard", 1'b1);
`endif
        step(1);
        check("t3_idle", 4'b0000);
        step(5);
        check("t3_start_ignored", 4'b0000);
        set_btn(4'b0000);
        step(10);

        // 4: start, stop and rst press events coincide
        set_btn(4'b1110);
        step(7);
        check("t4_pre", 4'b0000);
        step(1);
        check("t4_clear1", 4'b0010);
`ifdef CTRL_ERR_FLAG_EN
        check_err("t4_err_pulse", 1'b1);
`endif
        step(1);
        check("t4_clear2", 4'b0010);
`ifdef CTRL_ERR_FLAG_EN
        check_err("t4_err_single", 1'b0);
`endif
        step(1);
        check("t4_idle", 4'b0000);
        set_btn(4'b0000);
        step(10);

        // Vector table: toggle presses and state walk
        for (int i = 0; i < 16; i++) begin
            set_btn(tbl[i].btn);
            step(tbl[i].cyc);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // 5: toggle press landing inside CLEAR
        set_btn(4'b0010);
        step(1);
        set_btn(4'b0011);
        step(6);
        check("t5_pre", 4'b0000);
        step(1);
        check("t5_clear1", 4'b0010);
        step(1);
        check("t5_clear2_tgl", 4'b0011);
        step(1);
        check("t5_idle", 4'b0001);
        set_btn(4'b0000);
        step(10);

        // 6: async reset mid-CLEAR and mid-debounce, start held through release
        set_btn(4'b1000);
        step(10);
        check("t6_run", 4'b1001);
        set_btn(4'b1010);
        step(5);
        set_btn(4'b1011);
        step(3);
        check("t6_clear", 4'b0011);
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_reset", 4'b0000);
        step(3);
        set_btn(4'b1000);
        check("t6_in_reset", 4'b0000);
        rst = 1'b1;
        step(7);
        check("t6_post_edge6", 4'b0000);
        step(1);
        check("t6_post_edge7", 4'b1000);
        set_btn(4'b0000);
        step(10);
        check("t6_final", 4'b1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
